// File: rtl/nes_cpu_pkg.sv
// Shared NES 6502 pipeline definitions: instruction-size table, addressing-mode
// encodings and the bit positions of the fetch-to-decode word.
package nes_cpu_pkg;

  // Fetch-to-decode word layout
  localparam int unsigned FD_WIDTH      = 24;
  localparam int unsigned FD_OPCODE_LSB = 0;
  localparam int unsigned FD_BYTE1_LSB  = 8;
  localparam int unsigned FD_BYTE2_LSB  = 16;

  // Addressing modes as seen by decode_stage
  typedef enum logic [3:0] {
    AM_IMP = 4'd0,
    AM_ACC = 4'd1,
    AM_IMM = 4'd2,
    AM_ZP  = 4'd3,
    AM_ZPX = 4'd4,
    AM_ZPY = 4'd5,
    AM_ABS = 4'd6,
    AM_ABX = 4'd7,
    AM_ABY = 4'd8,
    AM_IND = 4'd9,
    AM_IZX = 4'd10,
    AM_IZY = 4'd11,
    AM_REL = 4'd12,
    AM_ILL = 4'd13
  } addr_mode_e;

  // Instruction byte count, row = opcode[7:4], column = opcode[3:0] (0..14).
  // 0 marks an opcode the core does not implement.
  localparam logic [1:0] INSTR_SIZE_TBL [16][15] = '{
    '{2'd1,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd2,2'd1,2'd0,2'd0,2'd3,2'd3}, // 0x
    '{2'd2,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd3,2'd0,2'd0,2'd0,2'd3,2'd3}, // 1x
    '{2'd3,2'd2,2'd0,2'd0,2'd2,2'd2,2'd2,2'd0,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd3}, // 2x
    '{2'd2,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd3,2'd0,2'd0,2'd0,2'd3,2'd3}, // 3x
    '{2'd1,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd3}, // 4x
    '{2'd2,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd3,2'd0,2'd0,2'd0,2'd3,2'd3}, // 5x
    '{2'd1,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd3}, // 6x
    '{2'd2,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd3,2'd0,2'd0,2'd0,2'd3,2'd3}, // 7x
    '{2'd0,2'd2,2'd0,2'd0,2'd2,2'd2,2'd2,2'd0,2'd1,2'd0,2'd1,2'd0,2'd3,2'd3,2'd3}, // 8x
    '{2'd2,2'd2,2'd0,2'd0,2'd2,2'd2,2'd2,2'd0,2'd1,2'd3,2'd1,2'd0,2'd0,2'd3,2'd0}, // 9x
    '{2'd2,2'd2,2'd2,2'd0,2'd2,2'd2,2'd2,2'd0,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd3}, // Ax
    '{2'd2,2'd2,2'd0,2'd0,2'd2,2'd2,2'd2,2'd0,2'd1,2'd3,2'd1,2'd0,2'd3,2'd3,2'd3}, // Bx
    '{2'd2,2'd2,2'd0,2'd0,2'd2,2'd2,2'd2,2'd0,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd3}, // Cx
    '{2'd2,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd3,2'd0,2'd0,2'd0,2'd3,2'd3}, // Dx
    '{2'd2,2'd2,2'd0,2'd0,2'd2,2'd2,2'd2,2'd0,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd3}, // Ex
    '{2'd2,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd3,2'd0,2'd0,2'd0,2'd3,2'd3}  // Fx
  };

  // Byte count of an opcode; column 15 holds no implemented opcodes.
  function automatic logic [1:0] instr_size(input logic [7:0] opcode);
    logic [1:0] size;
    if (opcode[3:0] == 4'hF) begin
      size = 2'd0;
    end else begin
      size = INSTR_SIZE_TBL[opcode[7:4]][opcode[3:0]];
    end
    return size;
  endfunction

endpackage

// File: rtl/opcode_len.sv
// Opcode sizing: instruction length (1..3) and an unsupported-opcode flag.
// Unsupported opcodes are treated as single-byte so fetch keeps advancing.
module opcode_len
  import nes_cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len,
  output logic       illegal
);

  logic [1:0] size;

  // Table lookup with illegal opcodes folded to length 1
  always_comb begin
    size    = instr_size(opcode);
    illegal = (size == 2'd0);
    len     = illegal ? 2'd1 : size;
  end

endmodule

// File: rtl/fetch_stage.sv
// NES 6502 fetch stage: reads opcode and operand bytes from synchronous
// byte-wide program memory and hands packed instructions to decode over a
// valid/ready handshake. Later stages can redirect the PC at any time.
// Build option NES_RESET_VECTOR_EN: fetch the start PC from FFFC/FFFD after
// reset instead of using RESET_PC.
module fetch_stage
  import nes_cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'hC000
) (
  input  logic                clk,
  input  logic                rst,
  output logic [15:0]         mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_rdata,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  output logic [FD_WIDTH-1:0] f_to_d_reg,
  output logic                f_valid,
  input  logic                d_ready,
  output logic [1:0]          f_len,
  output logic [15:0]         f_pc,
  output logic                f_illegal
);

`ifdef NES_RESET_VECTOR_EN
  typedef enum logic [2:0] {
    S_OP, S_D0, S_D1, S_D2, S_OUT, S_RV_LO, S_RV_HI, S_RV_END
  } state_e;
  localparam state_e RESET_STATE = S_RV_LO;
  localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;
  logic [7:0] vec_lo_q;
`else
  typedef enum logic [2:0] {
    S_OP, S_D0, S_D1, S_D2, S_OUT
  } state_e;
  localparam state_e RESET_STATE = S_OP;
`endif

  state_e      state_q, state_d;
  logic [15:0] pc_q;
  logic [15:0] fpc_q;
  logic [7:0]  opcode_q, byte1_q, byte2_q;
  logic [1:0]  len_q;
  logic        ill_q;
  logic [1:0]  len_c;
  logic        ill_c;

  // Size the opcode arriving from memory during S_D0
  opcode_len u_opcode_len (
    .opcode  (mem_rdata),
    .len     (len_c),
    .illegal (ill_c)
  );

  // State register; reset beats redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect restarts fetch from any state
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = S_OP;
    end else begin
      case (state_q)
        S_OP:     state_d = S_D0;
        S_D0:     state_d = (len_c >= 2'd2) ? S_D1 : S_OUT;
        S_D1:     state_d = (len_q == 2'd3) ? S_D2 : S_OUT;
        S_D2:     state_d = S_OUT;
        S_OUT:    state_d = d_ready ? S_OP : S_OUT;
`ifdef NES_RESET_VECTOR_EN
        S_RV_LO:  state_d = S_RV_HI;
        S_RV_HI:  state_d = S_RV_END;
        S_RV_END: state_d = S_OP;
`endif
        default:  state_d = S_OP;
      endcase
    end
  end

  // PC and instruction capture; bytes not fetched stay cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      fpc_q    <= '0;
      opcode_q <= '0;
      byte1_q  <= '0;
      byte2_q  <= '0;
      len_q    <= '0;
      ill_q    <= 1'b0;
`ifdef NES_RESET_VECTOR_EN
      vec_lo_q <= '0;
`endif
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else begin
      case (state_q)
        S_D0: begin
          fpc_q    <= pc_q;
          opcode_q <= mem_rdata;
          byte1_q  <= '0;
          byte2_q  <= '0;
          len_q    <= len_c;
          ill_q    <= ill_c;
        end
        S_D1:     byte1_q <= mem_rdata;
        S_D2:     byte2_q <= mem_rdata;
        S_OUT:    if (d_ready) pc_q <= pc_q + {14'd0, len_q};
`ifdef NES_RESET_VECTOR_EN
        S_RV_HI:  vec_lo_q <= mem_rdata;
        S_RV_END: pc_q <= {mem_rdata, vec_lo_q};
`endif
        default: ;
      endcase
    end
  end

  // Memory requests and decode-facing outputs
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_OP: mem_rd = 1'b1;
      S_D0: begin
        if (len_c >= 2'd2) begin
          mem_rd   = 1'b1;
          mem_addr = pc_q + 16'd1;
        end
      end
      S_D1: begin
        if (len_q == 2'd3) begin
          mem_rd   = 1'b1;
          mem_addr = pc_q + 16'd2;
        end
      end
`ifdef NES_RESET_VECTOR_EN
      S_RV_LO: begin
        mem_rd   = 1'b1;
        mem_addr = VEC_LO_ADDR;
      end
      S_RV_HI: begin
        mem_rd   = 1'b1;
        mem_addr = VEC_HI_ADDR;
      end
`endif
      default: ;
    endcase
    // No point issuing a read whose data would be flushed or reset away
    if (rst || redirect_valid) begin
      mem_rd   = 1'b0;
      mem_addr = '0;
    end

    f_valid    = (state_q == S_OUT);
    f_to_d_reg = '0;
    f_to_d_reg[FD_OPCODE_LSB +: 8] = opcode_q;
    f_to_d_reg[FD_BYTE1_LSB  +: 8] = byte1_q;
    f_to_d_reg[FD_BYTE2_LSB  +: 8] = byte2_q;
    f_len      = len_q;
    f_pc       = fpc_q;
    f_illegal  = ill_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: behavioural program memory, scoreboard of
// expected instructions checked at each decode handshake.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        d_ready = 1'b1;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [23:0] f_to_d_reg;
  logic        f_valid;
  logic [1:0]  f_len;
  logic [15:0] f_pc;
  logic        f_illegal;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] fd;
    logic [1:0]  len;
    logic [15:0] pc;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'hC000)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_to_d_reg     (f_to_d_reg),
    .f_valid        (f_valid),
    .d_ready        (d_ready),
    .f_len          (f_len),
    .f_pc           (f_pc),
    .f_illegal      (f_illegal)
  );

  // Synchronous memory; junk on idle cycles so stray latches show up
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);
  end

  // Scoreboard: every accepted instruction must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && f_valid && d_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got f_pc=%h f_to_d_reg=%h, expected no instruction", f_pc, f_to_d_reg);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (f_to_d_reg !== mon_e.fd) begin
          errors++;
          $display("FAIL sb_word @%h: got %h expected %h", mon_e.pc, f_to_d_reg, mon_e.fd);
        end
        checks++;
        if (f_len !== mon_e.len) begin
          errors++;
          $display("FAIL sb_len @%h: got %0d expected %0d", mon_e.pc, f_len, mon_e.len);
        end
        checks++;
        if (f_pc !== mon_e.pc) begin
          errors++;
          $display("FAIL sb_pc: got %h expected %h", f_pc, mon_e.pc);
        end
        checks++;
        if (f_illegal !== mon_e.ill) begin
          errors++;
          $display("FAIL sb_illegal @%h: got %b expected %b", mon_e.pc, f_illegal, mon_e.ill);
        end
      end
    end
  end

  // Advance negedge by negedge until f_valid, giving up after 20 cycles
  task automatic wait_valid(output int n);
    n = 0;
    while (f_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== 17'd0) begin
      errors++;
      $display("FAIL reset_mem: got rd=%b addr=%h expected 0/0000", mem_rd, mem_addr);
    end
    checks++;
    if ({f_valid, f_to_d_reg} !== 25'd0) begin
      errors++;
      $display("FAIL reset_word: got valid=%b word=%h expected 0/000000", f_valid, f_to_d_reg);
    end
    checks++;
    if ({f_len, f_pc, f_illegal} !== 19'd0) begin
      errors++;
      $display("FAIL reset_info: got len=%0d pc=%h ill=%b expected 0", f_len, f_pc, f_illegal);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
`ifdef NES_RESET_VECTOR_EN
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFC}) begin
      errors++;
      $display("FAIL vec_lo_read: got rd=%b addr=%h expected 1/FFFC", mem_rd, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFD}) begin
      errors++;
      $display("FAIL vec_hi_read: got rd=%b addr=%h expected 1/FFFD", mem_rd, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h8000}) begin
      errors++;
      $display("FAIL vec_first_op: got rd=%b addr=%h expected 1/8000", mem_rd, mem_addr);
    end
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 16'hC000;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
`endif
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hC000}) begin
      errors++;
      $display("FAIL first_read: got rd=%b addr=%h expected 1/C000", mem_rd, mem_addr);
    end
  endtask

  task automatic test_len2();
    int n;
    exp_q.push_back(exp_t'{24'h0042A9, 2'd2, 16'hC000, 1'b0});
    wait_valid(n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL lat_len2: got %0d cycles expected 3", n);
    end
    @(negedge clk);
    checks++;
    if ({f_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'hC002}) begin
      errors++;
      $display("FAIL next_after_len2: got v=%b rd=%b addr=%h expected 0/1/C002", f_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_len3();
    int n;
    exp_q.push_back(exp_t'{24'h12344C, 2'd3, 16'hC002, 1'b0});
    wait_valid(n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL lat_len3: got %0d cycles expected 4", n);
    end
    @(negedge clk);
    checks++;
    if ({f_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'hC005}) begin
      errors++;
      $display("FAIL next_after_len3: got v=%b rd=%b addr=%h expected 0/1/C005", f_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_illegal();
    int n;
    exp_q.push_back(exp_t'{24'h000002, 2'd1, 16'hC005, 1'b1});
    exp_q.push_back(exp_t'{24'h00000F, 2'd1, 16'hC006, 1'b1});
    wait_valid(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL lat_ill02: got %0d cycles expected 2", n);
    end
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hC006}) begin
      errors++;
      $display("FAIL next_after_02: got rd=%b addr=%h expected 1/C006", mem_rd, mem_addr);
    end
    wait_valid(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL lat_ill0F: got %0d cycles expected 2", n);
    end
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hC007}) begin
      errors++;
      $display("FAIL next_after_0F: got rd=%b addr=%h expected 1/C007", mem_rd, mem_addr);
    end
  endtask

  task automatic test_stall();
    int n;
    d_ready = 1'b0;
    exp_q.push_back(exp_t'{24'h0000EA, 2'd1, 16'hC007, 1'b0});
    wait_valid(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL lat_stall: got %0d cycles expected 2", n);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({f_valid, f_to_d_reg, f_len, f_pc, f_illegal} !== {1'b1, 24'h0000EA, 2'd1, 16'hC007, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b w=%h l=%0d pc=%h i=%b expected 1/0000EA/1/C007/0",
                 i, f_valid, f_to_d_reg, f_len, f_pc, f_illegal);
      end
      checks++;
      if (mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL stall_rd[%0d]: got %b expected 0", i, mem_rd);
      end
    end
    @(posedge clk);
    #1 d_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({f_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'hC008}) begin
      errors++;
      $display("FAIL after_stall: got v=%b rd=%b addr=%h expected 0/1/C008", f_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_redirect();
    int n;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hC009}) begin
      errors++;
      $display("FAIL redir_b1_read: got rd=%b addr=%h expected 1/C009", mem_rd, mem_addr);
    end
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 16'h8000;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'h8000}) begin
      errors++;
      $display("FAIL redir_target: got v=%b rd=%b addr=%h expected 0/1/8000", f_valid, mem_rd, mem_addr);
    end
    exp_q.push_back(exp_t'{24'h0000EA, 2'd1, 16'h8000, 1'b0});
    wait_valid(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL lat_redir: got %0d cycles expected 2", n);
    end
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    exp_q.push_back(exp_t'{24'h0010A5, 2'd2, 16'hFFFF, 1'b0});
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_op_read: got rd=%b addr=%h expected 1/FFFF", mem_rd, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_b1_read: got rd=%b addr=%h expected 1/0000", mem_rd, mem_addr);
    end
    wait_valid(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL lat_wrap: got %0d cycles expected 2", n);
    end
    @(negedge clk);
    checks++;
    if ({f_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL wrap_pc: got v=%b rd=%b addr=%h expected 0/1/0001", f_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({f_valid, mem_rd, f_to_d_reg} !== 26'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rd=%b w=%h expected 0/0/000000", f_valid, mem_rd, f_to_d_reg);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
`ifdef NES_RESET_VECTOR_EN
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFC}) begin
      errors++;
      $display("FAIL restart_read: got rd=%b addr=%h expected 1/FFFC", mem_rd, mem_addr);
    end
    exp_q.push_back(exp_t'{24'h0000EA, 2'd1, 16'h8000, 1'b0});
    wait_valid(n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL lat_restart: got %0d cycles expected 5", n);
    end
`else
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hC000}) begin
      errors++;
      $display("FAIL restart_read: got rd=%b addr=%h expected 1/C000", mem_rd, mem_addr);
    end
    exp_q.push_back(exp_t'{24'h0042A9, 2'd2, 16'hC000, 1'b0});
    wait_valid(n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL lat_restart: got %0d cycles expected 3", n);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h42;
    mem[16'hC002] = 8'h4C; mem[16'hC003] = 8'h34; mem[16'hC004] = 8'h12;
    mem[16'hC005] = 8'h02; mem[16'hC006] = 8'h0F; mem[16'hC007] = 8'hEA;
    mem[16'hC008] = 8'hAD; mem[16'hC009] = 8'h00; mem[16'hC00A] = 8'h20;
    mem[16'h8000] = 8'hEA;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'hFFFF] = 8'hA5; mem[16'h0000] = 8'h10;
    mem[16'h0001] = 8'hAD; mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;

    test_reset();
    test_len2();
    test_len3();
    test_illegal();
    test_stall();
    test_redirect();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the NES 6502 pipeline.
- Reads opcode and operand bytes from byte-wide synchronous program memory and sizes each instruction from the shared opcode size table.
- Packs each instruction into the 24-bit f_to_d_reg word consumed by decode_stage, using a valid/ready handshake.
- Supports PC redirect (jumps, branches, interrupts) from later stages.

Parameters:
- RESET_PC, 16'hC000, PC loaded on reset when the reset-vector feature is compiled out.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  reset, synchronous, active-high.
- mem_addr  out  16  program memory byte address.
- mem_rd  out  1  read strobe; mem_rdata is valid exactly one cycle after mem_rd=1.
- mem_rdata  in  8  read data.
- redirect_valid  in  1  one-cycle request to flush and restart at redirect_pc.
- redirect_pc  in  16  new fetch address.
- f_to_d_reg  out  24  [7:0]=opcode, [15:8]=operand byte1, [23:16]=operand byte2; unused bytes are 0.
- f_valid  out  1  f_to_d_reg, f_len, f_pc and f_illegal are valid.
- d_ready  in  1  decode accepts when f_valid & d_ready.
- f_len  out  2  instruction length, 1..3.
- f_pc  out  16  address of the opcode.
- f_illegal  out  1  opcode has size 0 in the table.

Behaviour:
- Reset: all outputs are 0, mem_rd=0, pc=RESET_PC, state=S_OP. In-flight memory data is ignored. Reset asserted mid-instruction abandons that instruction.
- Size lookup: row = opcode[7:4], column = opcode[3:0], using the shared table. Column 15, and any entry equal to 0, means unsupported: f_illegal=1, length treated as 1.
- FSM states:
  - S_OP: mem_rd=1, mem_addr=pc; go to S_D0.
  - S_D0: latch opcode=mem_rdata and compute len combinationally. If len≥2: mem_rd=1, mem_addr=pc+1, go to S_D1. Otherwise go to S_OUT.
  - S_D1: latch byte1. If len==3: mem_rd=1, mem_addr=pc+2, go to S_D2. Otherwise go to S_OUT.
  - S_D2: latch byte2; go to S_OUT.
  - S_OUT: f_valid=1 and all outputs are held stable. On d_ready: pc<=pc+len, f_valid drops, go to S_OP. While d_ready=0, mem_rd=0 (no memory traffic).
- Latency: opcode read issued at cycle 0; f_valid rises at cycle 2 for len1, cycle 3 for len2, cycle 4 for len3.
- Peak throughput: one instruction per len+2 cycles.
- Address arithmetic is 16-bit modulo: FFFF+1 wraps to 0000, for both operand fetches and PC increment.
- Redirect:
  - redirect_valid has priority over every state, including S_OUT with d_ready=1.
  - Next cycle: pc=redirect_pc, f_valid=0, state=S_OP. Any read returning that cycle is discarded.
  - The first read at redirect_pc is issued the cycle after redirect_valid.
- Simultaneous rst and redirect_valid: rst wins.
- f_to_d_reg byte lanes not fetched are forced to 0.

Optional Feature:
- Macro: NES_RESET_VECTOR_EN.
- Defined: reset enters S_RV_LO, which reads 16'hFFFC; S_RV_HI latches lo and reads 16'hFFFD; the next cycle latches hi, sets pc={hi,lo}, and enters S_OP. The first opcode read therefore occurs at cycle 3 after reset release. A redirect during the vector fetch aborts it, and redirect_pc is used.
- Undefined: pc=RESET_PC and the first read occurs at cycle 0 after reset release. RESET_PC is ignored when the macro is defined.

Decomposition:
- Package nes_cpu_pkg holds:
  - the 16x15 instruction-size table as a function instr_size(opcode) returning 2 bits;
  - the addressing-mode encoding constants (0..13);
  - the f_to_d field-position constants.
- decode_stage and fetch_stage both use nes_cpu_pkg.
- One sub-module is natural: opcode_len, a combinational wrapper producing len and illegal from the opcode. It is instantiated once.
- The FSM and PC stay in fetch_stage.

Test Plan:
1. Memory C000=A9, C001=42, d_ready=1 → f_valid at cycle 3; f_to_d_reg=24'h0042A9, f_len=2, f_pc=C000; next opcode read at C002.
2. C002=4C, C003=34, C004=12 → f_to_d_reg=24'h12344C, f_len=3; next mem_addr=C005.
3. Opcode 02, then opcode 0F → each gives f_illegal=1, f_len=1, f_to_d_reg=24'h000002 and 24'h00000F respectively; PC advances by 1 each.
4. d_ready low for 5 cycles during S_OUT → outputs unchanged, mem_rd=0 throughout; acceptance on the 6th cycle.
5. redirect_valid with redirect_pc=8000 during the S_D1 read of a 3-byte instruction → no f_valid for it; next mem_addr=8000. Opcode at FFFF with len2 → operand read from 0000.
6. NES_RESET_VECTOR_EN defined, FFFC=00, FFFD=80 → reads FFFC then FFFD, then the first opcode read at 8000. Reset asserted mid-S_D2 → f_valid=0 and the sequence restarts.
